// File: rtl/secuenciador_if.sv
// Decoder/stack <-> program-sequencer bundle. With SECUENCIADOR_INTR_EN defined,
// the interrupt request (irq) and return-from-interrupt (reti) strobes are added.
interface secuenciador_if;
    // Strobes and flags are plain levels qualified by the rising clock edge; there is
    // no valid/ready pairing: whatever is present at the edge is the current instruction.
    logic       jmp;
    logic       bz;
    logic       bnz;
    logic       call;
    logic       ret;
    logic       z;
    logic [9:0] target;
    logic [9:0] sp;
    logic       underflow;
    logic       overflow;
    logic       halt;
    logic       resume;
`ifdef SECUENCIADOR_INTR_EN
    logic       irq;
    logic       reti;
`endif
    logic [9:0] pc;
    logic [9:0] pc_addr;
    logic       push;
    logic       pop;
    logic       fault;
    logic       halted;
    logic [1:0] state;

`ifdef SECUENCIADOR_INTR_EN
    modport master (output jmp, bz, bnz, call, ret, z, target, sp, underflow, overflow,
                    halt, resume, irq, reti,
                    input  pc, pc_addr, push, pop, fault, halted, state);
    modport slave  (input  jmp, bz, bnz, call, ret, z, target, sp, underflow, overflow,
                    halt, resume, irq, reti,
                    output pc, pc_addr, push, pop, fault, halted, state);
`else
    modport master (output jmp, bz, bnz, call, ret, z, target, sp, underflow, overflow,
                    halt, resume,
                    input  pc, pc_addr, push, pop, fault, halted, state);
    modport slave  (input  jmp, bz, bnz, call, ret, z, target, sp, underflow, overflow,
                    halt, resume,
                    output pc, pc_addr, push, pop, fault, halted, state);
`endif
endinterface

// File: rtl/secuenciador.sv
// Program counter sequencer with RUN/HALT/FAULT control and return-stack strobes.
// Optional interrupt entry/return enabled by defining SECUENCIADOR_INTR_EN.
module secuenciador #(
    parameter logic [9:0] RESET_VECTOR = 10'h000,
    parameter logic [9:0] IRQ_VECTOR   = 10'h3F0
) (
    input  logic           clk,
    input  logic           reset,
    secuenciador_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] pc_q, pc_d;
    logic       fault_q, fault_d;
    logic       halted_q, halted_d;
    logic [9:0] pc_inc;
    logic       fault_in;
    logic       irq_take;
    logic       do_ret;
    logic       push_c;
    logic       pop_c;
    logic [9:0] pc_addr_c;

`ifdef SECUENCIADOR_INTR_EN
    logic in_isr_q, in_isr_d;
    assign irq_take = bus.irq & ~in_isr_q;
    assign do_ret   = bus.ret | bus.reti;
`else
    assign irq_take = 1'b0;
    assign do_ret   = bus.ret;
`endif

    assign pc_inc   = pc_q + 10'd1;
    assign fault_in = bus.underflow | bus.overflow;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        halted_d  = halted_q;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        pc_addr_c = pc_inc;
`ifdef SECUENCIADOR_INTR_EN
        in_isr_d  = in_isr_q;
`endif
        case (state_q)
            ST_RUN: begin
                // Faults and halt freeze the PC and suppress the op so the stack is untouched.
                if (fault_in) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (bus.halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (irq_take) begin
                    push_c    = 1'b1;
                    pc_addr_c = pc_q;
                    pc_d      = IRQ_VECTOR;
`ifdef SECUENCIADOR_INTR_EN
                    in_isr_d  = 1'b1;
`endif
                end else if (bus.call) begin
                    push_c = 1'b1;
                    pc_d   = bus.target;
                end else if (do_ret) begin
                    pop_c = 1'b1;
                    pc_d  = bus.sp;
`ifdef SECUENCIADOR_INTR_EN
                    if (bus.reti) in_isr_d = 1'b0;
`endif
                end else if (bus.jmp) begin
                    pc_d = bus.target;
                end else if (bus.bz) begin
                    pc_d = bus.z ? bus.target : pc_inc;
                end else if (bus.bnz) begin
                    pc_d = bus.z ? pc_inc : bus.target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_HALT: begin
                if (fault_in) begin
                    state_d  = ST_FAULT;
                    fault_d  = 1'b1;
                    halted_d = 1'b0;
                end else if (bus.resume && !bus.halt) begin
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d  = ST_FAULT;
                fault_d  = 1'b1;
                halted_d = 1'b0;
            end
        endcase
        // Stack strobes must stay quiet for the whole time reset is held.
        if (!reset) begin
            push_c = 1'b0;
            pop_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
`ifdef SECUENCIADOR_INTR_EN
            in_isr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            halted_q <= halted_d;
`ifdef SECUENCIADOR_INTR_EN
            in_isr_q <= in_isr_d;
`endif
        end
    end

    assign bus.pc      = pc_q;
    assign bus.pc_addr = pc_addr_c;
    assign bus.push    = push_c;
    assign bus.pop     = pop_c;
    assign bus.fault   = fault_q;
    assign bus.halted  = halted_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_secuenciador.sv
// Bench for secuenciador: vector table plus hand-written reset, fault/halt and interrupt sequences.
module tb_secuenciador;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    secuenciador_if ifc();

    secuenciador #(
        .RESET_VECTOR(10'h000),
        .IRQ_VECTOR  (10'h3F0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    // op bits: {irq, reti, call, ret, jmp, bz, bnz}
    localparam logic [6:0] O_NONE = 7'h00;
    localparam logic [6:0] O_BNZ  = 7'h01;
    localparam logic [6:0] O_BZ   = 7'h02;
    localparam logic [6:0] O_JMP  = 7'h04;
    localparam logic [6:0] O_RET  = 7'h08;
    localparam logic [6:0] O_CALL = 7'h10;
    localparam logic [6:0] O_RETI = 7'h20;
    localparam logic [6:0] O_IRQ  = 7'h40;
    // flag bits: {underflow, overflow, halt, resume}
    localparam logic [3:0] F_NONE = 4'h0;
    localparam logic [3:0] F_RES  = 4'h1;
    localparam logic [3:0] F_HALT = 4'h2;
    localparam logic [3:0] F_OF   = 4'h4;
    localparam logic [3:0] F_UF   = 4'h8;

    typedef struct {
        logic [6:0] ops;
        logic       z;
        logic [9:0] target;
        logic [9:0] sp;
        logic [3:0] flg;
        logic       e_push;
        logic       e_pop;
        logic [9:0] e_addr;
        logic [9:0] e_pc;
        logic       e_fault;
        logic       e_halted;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    vec_t tbl[28];
    logic [9:0] cur_pc;

    function automatic vec_t mk(input logic [6:0] ops, input logic z, input logic [9:0] target,
                                input logic [9:0] sp, input logic [3:0] flg, input logic e_push,
                                input logic e_pop, input logic [9:0] e_addr, input logic [9:0] e_pc,
                                input logic e_fault, input logic e_halted);
        vec_t v;
        v.ops = ops; v.z = z; v.target = target; v.sp = sp; v.flg = flg;
        v.e_push = e_push; v.e_pop = e_pop; v.e_addr = e_addr; v.e_pc = e_pc;
        v.e_fault = e_fault; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifc.jmp = 1'b0; ifc.bz = 1'b0; ifc.bnz = 1'b0; ifc.call = 1'b0; ifc.ret = 1'b0;
        ifc.z = 1'b0; ifc.target = '0; ifc.sp = '0;
        ifc.underflow = 1'b0; ifc.overflow = 1'b0; ifc.halt = 1'b0; ifc.resume = 1'b0;
`ifdef SECUENCIADOR_INTR_EN
        ifc.irq = 1'b0; ifc.reti = 1'b0;
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input vec_t v, input int idx);
        logic [11:0] e;
        ifc.bnz = v.ops[0]; ifc.bz = v.ops[1]; ifc.jmp = v.ops[2];
        ifc.ret = v.ops[3]; ifc.call = v.ops[4];
`ifdef SECUENCIADOR_INTR_EN
        ifc.reti = v.ops[5]; ifc.irq = v.ops[6];
`endif
        ifc.z = v.z; ifc.target = v.target; ifc.sp = v.sp;
        ifc.resume = v.flg[0]; ifc.halt = v.flg[1];
        ifc.overflow = v.flg[2]; ifc.underflow = v.flg[3];
        #1;
        chk("push", idx, 32'(ifc.push), 32'(v.e_push));
        chk("pop", idx, 32'(ifc.pop), 32'(v.e_pop));
        chk("pc_addr", idx, 32'(ifc.pc_addr), 32'(v.e_addr));
        exp_q.push_back({v.e_pc, v.e_fault, v.e_halted});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pc", idx, 32'(ifc.pc), 32'(e[11:2]));
        chk("fault", idx, 32'(ifc.fault), 32'(e[1]));
        chk("halted", idx, 32'(ifc.halted), 32'(e[0]));
        @(negedge clk);
    endtask

    // Asserts reset immediately, checks the asynchronous effect, releases at a falling edge.
    task automatic do_reset(input int idx);
        reset = 1'b0;
        #1;
        chk("rst_pc", idx, 32'(ifc.pc), 32'h000);
        chk("rst_fault", idx, 32'(ifc.fault), 32'h0);
        chk("rst_halted", idx, 32'(ifc.halted), 32'h0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(O_JMP,         0, 10'h010, 10'h000, F_NONE, 0, 0, 10'h001, 10'h010, 0, 0);
        tbl[1]  = mk(O_CALL,        0, 10'h200, 10'h000, F_NONE, 1, 0, 10'h011, 10'h200, 0, 0);
        tbl[2]  = mk(O_RET,         0, 10'h000, 10'h011, F_NONE, 0, 1, 10'h201, 10'h011, 0, 0);
        tbl[3]  = mk(O_JMP,         0, 10'h3FF, 10'h000, F_NONE, 0, 0, 10'h012, 10'h3FF, 0, 0);
        tbl[4]  = mk(O_NONE,        0, 10'h000, 10'h000, F_NONE, 0, 0, 10'h000, 10'h000, 0, 0);
        tbl[5]  = mk(O_JMP,         0, 10'h3FF, 10'h000, F_NONE, 0, 0, 10'h001, 10'h3FF, 0, 0);
        tbl[6]  = mk(O_CALL,        0, 10'h100, 10'h000, F_NONE, 1, 0, 10'h000, 10'h100, 0, 0);
        tbl[7]  = mk(O_JMP,         0, 10'h020, 10'h000, F_NONE, 0, 0, 10'h101, 10'h020, 0, 0);
        tbl[8]  = mk(O_BZ,          0, 10'h050, 10'h000, F_NONE, 0, 0, 10'h021, 10'h021, 0, 0);
        tbl[9]  = mk(O_JMP,         0, 10'h020, 10'h000, F_NONE, 0, 0, 10'h022, 10'h020, 0, 0);
        tbl[10] = mk(O_BZ,          1, 10'h050, 10'h000, F_NONE, 0, 0, 10'h021, 10'h050, 0, 0);
        tbl[11] = mk(O_BNZ,         1, 10'h080, 10'h000, F_NONE, 0, 0, 10'h051, 10'h051, 0, 0);
        tbl[12] = mk(O_BNZ,         0, 10'h080, 10'h000, F_NONE, 0, 0, 10'h052, 10'h080, 0, 0);
        tbl[13] = mk(O_CALL|O_JMP,  0, 10'h123, 10'h000, F_NONE, 1, 0, 10'h081, 10'h123, 0, 0);
        tbl[14] = mk(O_RET|O_JMP,   0, 10'h222, 10'h060, F_NONE, 0, 1, 10'h124, 10'h060, 0, 0);
        tbl[15] = mk(O_BZ|O_BNZ,    0, 10'h070, 10'h000, F_NONE, 0, 0, 10'h061, 10'h061, 0, 0);
        tbl[16] = mk(O_NONE,        0, 10'h000, 10'h000, F_HALT, 0, 0, 10'h062, 10'h061, 0, 1);
        tbl[17] = mk(O_CALL,        0, 10'h300, 10'h000, F_NONE, 0, 0, 10'h062, 10'h061, 0, 1);
        tbl[18] = mk(O_NONE,        0, 10'h000, 10'h000, F_HALT|F_RES, 0, 0, 10'h062, 10'h061, 0, 1);
        tbl[19] = mk(O_NONE,        0, 10'h000, 10'h000, F_RES,  0, 0, 10'h062, 10'h061, 0, 0);
        tbl[20] = mk(O_NONE,        0, 10'h000, 10'h000, F_NONE, 0, 0, 10'h062, 10'h062, 0, 0);
        tbl[21] = mk(O_JMP,         0, 10'h030, 10'h000, F_NONE, 0, 0, 10'h063, 10'h030, 0, 0);
        tbl[22] = mk(O_NONE,        0, 10'h000, 10'h000, F_UF,   0, 0, 10'h031, 10'h030, 1, 0);
        tbl[23] = mk(O_NONE,        0, 10'h000, 10'h000, F_NONE, 0, 0, 10'h031, 10'h030, 1, 0);
        tbl[24] = mk(O_NONE,        0, 10'h000, 10'h000, F_RES,  0, 0, 10'h031, 10'h030, 1, 0);
        tbl[25] = mk(O_CALL,        0, 10'h200, 10'h000, F_NONE, 0, 0, 10'h031, 10'h030, 1, 0);
        tbl[26] = mk(O_RET,         0, 10'h000, 10'h111, F_NONE, 0, 0, 10'h031, 10'h030, 1, 0);
        tbl[27] = mk(O_JMP,         0, 10'h155, 10'h000, F_NONE, 0, 0, 10'h031, 10'h030, 1, 0);

        // Reset held from time 0 with a call strobe present: must be ignored.
        clear_inputs();
        ifc.call = 1'b1;
        ifc.target = 10'h2AA;
        #3;
        chk("init_pc", 0, 32'(ifc.pc), 32'h000);
        chk("init_push", 0, 32'(ifc.push), 32'h0);
        chk("init_pop", 0, 32'(ifc.pop), 32'h0);
        chk("init_fault", 0, 32'(ifc.fault), 32'h0);
        chk("init_halted", 0, 32'(ifc.halted), 32'h0);
        chk("init_state", 0, 32'(ifc.state), 32'h0);
        @(posedge clk);
        #1;
        chk("init_hold_pc", 0, 32'(ifc.pc), 32'h000);
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;

        for (int i = 0; i < 28; i++) drive(tbl[i], i);

        // Leave FAULT through reset, then reset mid-cycle at pc 0x123.
        do_reset(100);
        drive(mk(O_JMP, 0, 10'h123, 10'h000, F_NONE, 0, 0, 10'h001, 10'h123, 0, 0), 101);
        ifc.call = 1'b1;
        ifc.target = 10'h200;
        #1;
        chk("pre_rst_push", 102, 32'(ifc.push), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pc", 102, 32'(ifc.pc), 32'h000);
        chk("mid_rst_push", 102, 32'(ifc.push), 32'h0);
        chk("mid_rst_pop", 102, 32'(ifc.pop), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_pc", 102, 32'(ifc.pc), 32'h000);
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;

        // Halt and overflow together: fault wins.
        drive(mk(O_NONE, 0, 10'h000, 10'h000, F_HALT|F_OF, 0, 0, 10'h001, 10'h000, 1, 0), 103);
        do_reset(104);
        // Fault flag while halted still reaches FAULT.
        drive(mk(O_NONE, 0, 10'h000, 10'h000, F_HALT, 0, 0, 10'h001, 10'h000, 0, 1), 105);
        drive(mk(O_NONE, 0, 10'h000, 10'h000, F_OF,   0, 0, 10'h001, 10'h000, 1, 0), 106);
        drive(mk(O_NONE, 0, 10'h000, 10'h000, F_RES,  0, 0, 10'h001, 10'h000, 1, 0), 107);
        do_reset(108);

        // Random jumps: return address always tracks the current pc.
        cur_pc = 10'h000;
        for (int i = 0; i < 8; i++) begin
            logic [9:0] t;
            t = 10'($urandom_range(0, 1023));
            drive(mk(O_JMP, 0, t, 10'h000, F_NONE, 0, 0, cur_pc + 10'd1, t, 0, 0), 200 + i);
            cur_pc = t;
        end

`ifdef SECUENCIADOR_INTR_EN
        do_reset(300);
        drive(mk(O_JMP,         0, 10'h040, 10'h000, F_NONE, 0, 0, 10'h001, 10'h040, 0, 0), 301);
        drive(mk(O_IRQ|O_CALL,  0, 10'h200, 10'h000, F_NONE, 1, 0, 10'h040, 10'h3F0, 0, 0), 302);
        drive(mk(O_IRQ,         0, 10'h000, 10'h000, F_NONE, 0, 0, 10'h3F1, 10'h3F1, 0, 0), 303);
        drive(mk(O_RETI,        0, 10'h000, 10'h040, F_NONE, 0, 1, 10'h3F2, 10'h040, 0, 0), 304);
        drive(mk(O_IRQ,         0, 10'h000, 10'h000, F_NONE, 1, 0, 10'h040, 10'h3F0, 0, 0), 305);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secuenciador.md
SECUENCIADOR -- requirements
Module: secuenciador

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 10'h000, the PC value loaded on reset.
REQ-002 SHALL have parameter IRQ_VECTOR, default 10'h3F0, the interrupt entry address (used only with INTR_EN).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports jmp, bz, bnz, call, ret  input  1 each  control-op strobes from the decoder for the current instruction.
REQ-006 SHALL have port z  input  1  ALU zero flag.
REQ-007 SHALL have port target  input  10  jump/branch/call destination.
REQ-008 SHALL have port sp  input  10  return-stack top value.
REQ-009 SHALL have ports underflow, overflow  input  1 each  return-stack fault flags.
REQ-010 SHALL have ports halt, resume  input  1 each  freeze/unfreeze request.
REQ-011 SHALL have port pc  output  10  registered program counter.
REQ-012 SHALL have port pc_addr  output  10  return address to stack (pc+1, or pc on interrupt).
REQ-013 SHALL have ports push, pop  output  1 each  combinational stack strobes, asserted only in RUN.
REQ-014 SHALL have ports fault, halted  output  1 each  registered status.

Function
REQ-015 SHALL implement FSM RUN, HALT, FAULT; PC advances only in RUN.
REQ-016 SHALL, in RUN, resolve op priority call > ret > jmp > bz > bnz > sequential; lower ops ignored.
REQ-017 SHALL, for call: push=1, pc_addr=pc+1, next pc=target.
REQ-018 SHALL, for ret: pop=1, next pc=sp sampled this cycle.
REQ-019 SHALL, for jmp: next pc=target; bz: target if z=1 else pc+1; bnz: target if z=0 else pc+1.
REQ-020 SHALL compute pc+1 modulo 2^10 (10'h3FF wraps to 10'h000), including pc_addr.
REQ-021 SHALL hold pc_addr = pc+1 when no push occurs.
REQ-022 SHALL move RUN->FAULT when overflow or underflow is 1 at a rising edge; pc not updated that edge; FAULT exits only via reset.
REQ-023 SHALL move RUN->HALT on halt=1 (pc not updated that edge); HALT->RUN on resume=1 with halt=0; fault flags in HALT still move to FAULT.
REQ-024 SHALL, if halt and a fault flag coincide, enter FAULT.
REQ-025 SHALL drive fault=1 only in FAULT and halted=1 only in HALT, with push=pop=0 outside RUN.
REQ-026 SHALL have next-PC latency of one cycle: ops sampled at edge N set pc after edge N.

Reset
REQ-027 SHALL on reset=0 immediately set pc=RESET_VECTOR, state=RUN, fault=0, halted=0, independent of clk.
REQ-028 SHALL drive push=pop=0 while reset=0 and ignore all other inputs.
REQ-029 SHALL resume normal op at the first rising edge after reset deasserts, from RESET_VECTOR.

Configuration
REQ-030 SHALL support macro SECUENCIADOR_INTR_EN; when undefined, no ports irq/reti exist and behaviour is REQ-015..029 only.
REQ-031 SHALL, with SECUENCIADOR_INTR_EN, add inputs irq and reti (1 bit each) and internal mask bit in_isr (reset 0).
REQ-032 SHALL, with macro, in RUN when irq=1 and in_isr=0: override all ops, push=1, pc_addr=pc, next pc=IRQ_VECTOR, set in_isr.
REQ-033 SHALL, with macro, treat reti as ret (pop, pc=sp) and clear in_isr; reti ranks with ret in priority.

Verification
REQ-034 SHALL cover: reset low mid-cycle at pc=10'h123 -> pc=10'h000 immediately, push=pop=0.
REQ-035 SHALL cover: pc=10'h010, call, target=10'h200 -> push=1, pc_addr=10'h011, next pc=10'h200; then ret with sp=10'h011 -> pop=1, pc=10'h011.
REQ-036 SHALL cover: pc=10'h3FF sequential -> pc=10'h000; call at 10'h3FF -> pc_addr=10'h000.
REQ-037 SHALL cover: bz with z=0, target=10'h050 at pc=10'h020 -> pc=10'h021; z=1 -> pc=10'h050; call+jmp together -> call wins.
REQ-038 SHALL cover: underflow=1 at pc=10'h030 -> FAULT, fault=1, pc stays 10'h030 across 5 edges and resume; halt then resume -> pc frozen then continues.
REQ-039 SHALL cover (macro on): irq=1 at pc=10'h040 with call asserted -> push, pc_addr=10'h040, pc=IRQ_VECTOR; second irq ignored until reti with sp=10'h040 -> pc=10'h040.
